// File: rtl/chx_pkg.sv
// Shared definitions for the channel packet arbiter: FSM states, default
// widths and the round-robin one-hot pick used by the selector.
package chx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_NUM_CH    = 8;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ID_W      = 3;
    localparam int DEF_MAX_BEATS = 256;
    localparam int MAX_CH        = 32;

    // Masked-priority round robin: lowest set bit at or above ptr, else the
    // lowest set bit overall (wrap-around). Result is one-hot or zero.
    function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                  input logic [4:0] ptr);
        logic [MAX_CH-1:0] upper;
        logic [MAX_CH-1:0] masked;
        upper  = ~((32'd1 << ptr) - 32'd1);
        masked = req & upper;
        if (masked != '0) begin
            return masked & (~masked + 32'd1);
        end
        return req & (~req + 32'd1);
    endfunction

endpackage

// File: rtl/chx_pkt_arb_if.sv
// Channel-side and egress-side signal bundle of the packet arbiter.
// master is the arbiter's view, slave is the sources/egress view.
interface chx_pkt_arb_if #(
    parameter int NUM_CH = chx_pkg::DEF_NUM_CH,
    parameter int DATA_W = chx_pkg::DEF_DATA_W,
    parameter int ID_W   = chx_pkg::DEF_ID_W,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_qos;
    logic [NUM_CH-1:0]        ch_vld;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_sop;
    logic [NUM_CH-1:0]        ch_eop;
    logic [NUM_CH-1:0]        ch_ack;
    logic [ID_W-1:0]          chx_id_in;
    logic                     out_ready;
    logic                     out_vld;
    logic [DATA_W-1:0]        out_data;
    logic                     out_sop;
    logic                     out_eop;
    logic                     out_qos;
    logic [CH_W-1:0]          out_ch;
    logic [ID_W-1:0]          chx_id_out;
    logic                     chx_out_incr;
    logic                     err_timeout;

    modport master (
        input  ch_req, ch_qos, ch_vld, ch_data, ch_sop, ch_eop, chx_id_in, out_ready,
        output ch_ack, out_vld, out_data, out_sop, out_eop, out_qos, out_ch,
               chx_id_out, chx_out_incr, err_timeout
    );

    modport slave (
        output ch_req, ch_qos, ch_vld, ch_data, ch_sop, ch_eop, chx_id_in, out_ready,
        input  ch_ack, out_vld, out_data, out_sop, out_eop, out_qos, out_ch,
               chx_id_out, chx_out_incr, err_timeout
    );
endinterface

// File: rtl/chx_rr_pick.sv
// Combinational round-robin selector: one-hot pick from req starting at ptr,
// encoded to a channel index.
module chx_rr_pick
    import chx_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   idx
);
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   idx_terms [NUM_CH];

    assign grant = NUM_CH'(rr_pick(32'(req), 5'(ptr)));

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_enc
        assign idx_terms[gi] = grant[gi] ? CH_W'(gi) : '0;
    end

    // OR-reduce the per-channel index terms; grant is one-hot so this encodes it.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = idx | idx_terms[i];
        end
    end
endmodule

// File: rtl/chx_pkt_arb.sv
// Packet-level output arbiter: two-class round robin, grant locked for a whole
// packet, one-deep registered output stage with backpressure, beat watchdog.
module chx_pkt_arb
    import chx_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ID_W      = DEF_ID_W,
    parameter int CH_W      = $clog2(NUM_CH),
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input logic           clk,
    input logic           rst,
    chx_pkt_arb_if.master bus
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    state_t             state_reg, state_next;
    logic [CH_W-1:0]    g_reg, g_next;
    logic [CH_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic               qos_reg, qos_next;
    logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic               out_vld_reg, out_vld_next;
    logic [DATA_W-1:0]  out_data_reg, out_data_next;
    logic               out_sop_reg, out_sop_next;
    logic               out_eop_reg, out_eop_next;
    logic               out_qos_reg, out_qos_next;
    logic [CH_W-1:0]    out_ch_reg, out_ch_next;
    logic               incr_reg, incr_next;
    logic               err_reg, err_next;

    logic [NUM_CH-1:0]  qos_req;
    logic [NUM_CH-1:0]  cand;
    logic [CH_W-1:0]    pick_idx;
    logic [DATA_W-1:0]  data_arr [NUM_CH];
    logic               stall, ack_en, accept, last_beat;

    // QoS requests shadow normal ones; one shared pointer serves both classes.
    assign qos_req = bus.ch_req & bus.ch_qos;
    assign cand    = (qos_req != '0) ? qos_req : bus.ch_req;

    chx_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
        .req (cand),
        .ptr (rr_ptr_reg),
        .idx (pick_idx)
    );

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign data_arr[gi]   = bus.ch_data[gi*DATA_W +: DATA_W];
        assign bus.ch_ack[gi] = ack_en & (g_reg == CH_W'(gi));
    end

    assign stall     = out_vld_reg & ~bus.out_ready;
    assign ack_en    = (state_reg == BUSY) & ~stall;
    assign accept    = ack_en & bus.ch_vld[g_reg];
    assign last_beat = (beat_cnt_reg == CNT_W'(MAX_BEATS - 1));

    // Next-state logic for the grant FSM, watchdog and output register.
    always_comb begin
        state_next    = state_reg;
        g_next        = g_reg;
        rr_ptr_next   = rr_ptr_reg;
        qos_next      = qos_reg;
        beat_cnt_next = beat_cnt_reg;
        out_vld_next  = out_vld_reg;
        out_data_next = out_data_reg;
        out_sop_next  = out_sop_reg;
        out_eop_next  = out_eop_reg;
        out_qos_next  = out_qos_reg;
        out_ch_next   = out_ch_reg;
        incr_next     = 1'b0;
        err_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.ch_req != '0) begin
                    g_next        = pick_idx;
                    qos_next      = (qos_req != '0);
                    rr_ptr_next   = (pick_idx == CH_W'(NUM_CH - 1)) ? '0 : pick_idx + CH_W'(1);
                    beat_cnt_next = '0;
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    if (bus.ch_eop[g_reg] | last_beat) begin
                        state_next = IDLE;
                        incr_next  = 1'b1;
                        // A genuine eop on the limit beat is a normal completion.
                        err_next   = ~bus.ch_eop[g_reg];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (accept) begin
            out_vld_next  = 1'b1;
            out_data_next = data_arr[g_reg];
            out_sop_next  = bus.ch_sop[g_reg];
            out_eop_next  = bus.ch_eop[g_reg] | last_beat;
            out_qos_next  = qos_reg;
            out_ch_next   = g_reg;
        end else if (!stall) begin
            out_vld_next  = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            g_reg        <= '0;
            rr_ptr_reg   <= '0;
            qos_reg      <= 1'b0;
            beat_cnt_reg <= '0;
            out_vld_reg  <= 1'b0;
            out_data_reg <= '0;
            out_sop_reg  <= 1'b0;
            out_eop_reg  <= 1'b0;
            out_qos_reg  <= 1'b0;
            out_ch_reg   <= '0;
            incr_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            g_reg        <= g_next;
            rr_ptr_reg   <= rr_ptr_next;
            qos_reg      <= qos_next;
            beat_cnt_reg <= beat_cnt_next;
            out_vld_reg  <= out_vld_next;
            out_data_reg <= out_data_next;
            out_sop_reg  <= out_sop_next;
            out_eop_reg  <= out_eop_next;
            out_qos_reg  <= out_qos_next;
            out_ch_reg   <= out_ch_next;
            incr_reg     <= incr_next;
            err_reg      <= err_next;
        end
    end

    assign bus.out_vld      = out_vld_reg;
    assign bus.out_data     = out_data_reg;
    assign bus.out_sop      = out_sop_reg;
    assign bus.out_eop      = out_eop_reg;
    assign bus.out_qos      = out_qos_reg;
    assign bus.out_ch       = out_ch_reg;
    assign bus.chx_id_out   = out_vld_reg ? bus.chx_id_in : '0;
    assign bus.chx_out_incr = incr_reg;
    assign bus.err_timeout  = err_reg;
endmodule

// File: tb/tb_chx_pkt_arb.sv
// Directed per-cycle vector table for chx_pkt_arb (8 channels, watchdog 4).
// Each row holds the inputs applied in one cycle and the outputs expected
// in that same cycle (registered outputs from the previous edge, ack live).
module tb_chx_pkt_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    chx_pkt_arb_if #(.NUM_CH(8), .DATA_W(8), .ID_W(3)) bus ();

    chx_pkt_arb #(.NUM_CH(8), .DATA_W(8), .ID_W(3), .MAX_BEATS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       rst;
        logic       chk;
        logic       zchk;
        logic [7:0] req, qos, vld, sop, eop;
        logic [3:0] d;
        logic       rdy;
        logic [7:0] ack;
        logic       ov;
        logic [7:0] od;
        logic       os, oe, oq, inc, err;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_row = 0;

    function automatic vec_t r(input logic [7:0] req, qos, vld, sop, eop,
                               input logic [3:0] d, input logic rdy,
                               input logic [7:0] ack, input logic ov,
                               input logic [7:0] od,
                               input logic os, oe, oq, inc, err);
        vec_t v;
        v.rst = 1'b0; v.chk = 1'b1; v.zchk = 1'b0;
        v.req = req; v.qos = qos; v.vld = vld; v.sop = sop; v.eop = eop;
        v.d = d; v.rdy = rdy; v.ack = ack; v.ov = ov; v.od = od;
        v.os = os; v.oe = oe; v.oq = oq; v.inc = inc; v.err = err;
        return v;
    endfunction

    // Row whose outputs must all be at reset values.
    function automatic vec_t rz(input logic [7:0] req, qos, vld, sop, eop,
                                input logic [3:0] d, input logic [7:0] ack);
        vec_t v;
        v = r(req, qos, vld, sop, eop, d, 1'b1, ack, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v.zchk = 1'b1;
        return v;
    endfunction

    // Reset cycle: nothing compared.
    function automatic vec_t rr();
        vec_t v;
        v = r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v.rst = 1'b1;
        v.chk = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d actual %h required %h", name, cur_row, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [63:0] dat;
        for (int i = 0; i < 8; i++) dat[i*8 +: 8] = {i[3:0], v.d};
        rst           = v.rst;
        bus.ch_req    = v.req;
        bus.ch_qos    = v.qos;
        bus.ch_vld    = v.vld;
        bus.ch_sop    = v.sop;
        bus.ch_eop    = v.eop;
        bus.ch_data   = dat;
        bus.out_ready = v.rdy;
    endtask

    task automatic compare(input vec_t v);
        chk("ch_ack", 32'(bus.ch_ack), 32'(v.ack));
        chk("out_vld", 32'(bus.out_vld), 32'(v.ov));
        chk("chx_out_incr", 32'(bus.chx_out_incr), 32'(v.inc));
        chk("err_timeout", 32'(bus.err_timeout), 32'(v.err));
        chk("chx_id_out", 32'(bus.chx_id_out), v.ov ? 32'd5 : 32'd0);
        if (v.ov) begin
            chk("out_data", 32'(bus.out_data), 32'(v.od));
            chk("out_ch", 32'(bus.out_ch), 32'(v.od[6:4]));
            chk("out_sop", 32'(bus.out_sop), 32'(v.os));
            chk("out_eop", 32'(bus.out_eop), 32'(v.oe));
            chk("out_qos", 32'(bus.out_qos), 32'(v.oq));
        end
        if (v.zchk) begin
            chk("rst_out_data", 32'(bus.out_data), 32'd0);
            chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
            chk("rst_out_sop", 32'(bus.out_sop), 32'd0);
            chk("rst_out_eop", 32'(bus.out_eop), 32'd0);
            chk("rst_out_qos", 32'(bus.out_qos), 32'd0);
        end
    endtask

    initial begin
        bus.chx_id_in = 3'd5;
        apply(rr());

        // Normal class ch2 then ch5, 3-beat packets; then ch5/ch6 prove rr_ptr = 6.
        tbl.push_back(rz(8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00));
        tbl.push_back(r(8'h24, 8'h00, 8'h04, 8'h04, 8'h00, 4'h1, 1, 8'h04, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h24, 8'h00, 8'h04, 8'h00, 8'h00, 4'h2, 1, 8'h04, 1, 8'h21, 1, 0, 0, 0, 0));
        tbl.push_back(r(8'h24, 8'h00, 8'h04, 8'h00, 8'h04, 4'h3, 1, 8'h04, 1, 8'h22, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 1, 8'h23, 0, 1, 0, 1, 0));
        tbl.push_back(r(8'h20, 8'h00, 8'h20, 8'h20, 8'h00, 4'h1, 1, 8'h20, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h20, 8'h00, 8'h20, 8'h00, 8'h00, 4'h2, 1, 8'h20, 1, 8'h51, 1, 0, 0, 0, 0));
        tbl.push_back(r(8'h20, 8'h00, 8'h20, 8'h00, 8'h20, 4'h3, 1, 8'h20, 1, 8'h52, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 1, 8'h53, 0, 1, 0, 1, 0));
        tbl.push_back(r(8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h60, 8'h00, 8'h40, 8'h40, 8'h40, 4'h1, 1, 8'h40, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 1, 8'h61, 1, 1, 0, 1, 0));
        tbl.push_back(r(8'h20, 8'h00, 8'h20, 8'h20, 8'h20, 4'h2, 1, 8'h20, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 1, 8'h52, 1, 1, 0, 1, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(rr());
        // ch1 normal + ch6 QoS from rr_ptr 0: ch6 first with out_qos, then ch1.
        tbl.push_back(rz(8'h42, 8'h40, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00));
        tbl.push_back(r(8'h42, 8'h40, 8'h40, 8'h40, 8'h40, 4'h1, 1, 8'h40, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 1, 8'h61, 1, 1, 1, 1, 0));
        tbl.push_back(r(8'h02, 8'h00, 8'h02, 8'h02, 8'h02, 4'h2, 1, 8'h02, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 1, 8'h12, 1, 1, 0, 1, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        // ch3 4-beat packet, 2 stall cycles on beat 2; eop on the limit beat.
        tbl.push_back(r(8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h08, 8'h00, 8'h08, 8'h08, 8'h00, 4'h1, 1, 8'h08, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h08, 8'h00, 8'h08, 8'h00, 8'h00, 4'h2, 1, 8'h08, 1, 8'h31, 1, 0, 0, 0, 0));
        tbl.push_back(r(8'h08, 8'h00, 8'h08, 8'h00, 8'h00, 4'h3, 0, 8'h00, 1, 8'h32, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h08, 8'h00, 8'h08, 8'h00, 8'h00, 4'h3, 0, 8'h00, 1, 8'h32, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h08, 8'h00, 8'h08, 8'h00, 8'h00, 4'h3, 1, 8'h08, 1, 8'h32, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h08, 8'h00, 8'h08, 8'h00, 8'h08, 4'h4, 1, 8'h08, 1, 8'h33, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 1, 8'h34, 0, 1, 0, 1, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        // ch4 runaway packet: beat 4 forced eop, timeout, beats 5-6 not acked.
        tbl.push_back(r(8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h10, 8'h00, 8'h10, 8'h10, 8'h00, 4'h1, 1, 8'h10, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 4'h2, 1, 8'h10, 1, 8'h41, 1, 0, 0, 0, 0));
        tbl.push_back(r(8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 4'h3, 1, 8'h10, 1, 8'h42, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 4'h4, 1, 8'h10, 1, 8'h43, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 4'h5, 1, 8'h00, 1, 8'h44, 0, 1, 0, 1, 1));
        tbl.push_back(r(8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 4'h6, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(rr());
        // All 8 channels requesting single-beat packets: grants 0..7 then 0.
        for (int k = 0; k <= 8; k++) begin
            logic [2:0] pch;
            pch = 3'(k - 1);
            tbl.push_back(r(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 4'h7, 1, 8'h00, k > 0,
                            {1'b0, pch, 4'h7}, 1, 1, 0, k > 0, 0));
            tbl.push_back(r(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 4'h7, 1, 8'(1 << (k % 8)), 0,
                            8'h00, 0, 0, 0, 0, 0));
        end
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 1, 8'h07, 1, 1, 0, 1, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(rr());
        // ch6 packet, reset on beat 2; afterwards IDLE and rr_ptr 0 (ch1 beats ch6).
        tbl.push_back(r(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h40, 8'h00, 8'h40, 8'h40, 8'h00, 4'h1, 1, 8'h40, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(rr());
        tbl.push_back(rz(8'h42, 8'h00, 8'h40, 8'h40, 8'h00, 4'h3, 8'h00));
        tbl.push_back(r(8'h42, 8'h00, 8'h02, 8'h02, 8'h02, 4'h1, 1, 8'h02, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 1, 8'h11, 1, 1, 0, 1, 0));
        tbl.push_back(r(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            cur_row = i;
            apply(tbl[i]);
            #1;
            if (tbl[i].chk) begin
                compare(tbl[i]);
                $display("row %0d req %h ack %h out_vld %b data %h sop %b eop %b qos %b incr %b err %b",
                         i, bus.ch_req, bus.ch_ack, bus.out_vld, bus.out_data, bus.out_sop,
                         bus.out_eop, bus.out_qos, bus.chx_out_incr, bus.err_timeout);
            end else begin
                $display("row %0d reset", i);
            end
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
